// File: rtl/steer_pkg.sv
// Shared types for the quadrature steering encoder: phase codes, request
// direction and the phase-advance helper.
package steer_pkg;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  // Gray-code walk: RIGHT goes PH0->PH1->PH2->PH3, LEFT walks it backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input dir_e d);
    logic [1:0] nx;
    nx = ph;
    if (d == DIR_RIGHT) begin
      case (ph)
        PH0:     nx = PH1;
        PH1:     nx = PH2;
        PH2:     nx = PH3;
        default: nx = PH0;
      endcase
    end else if (d == DIR_LEFT) begin
      case (ph)
        PH0:     nx = PH3;
        PH3:     nx = PH2;
        PH2:     nx = PH1;
        default: nx = PH0;
      endcase
    end
    return nx;
  endfunction

endpackage

// File: rtl/steer_quad_chan.sv
// One steering channel: direction tracker, step counter, accelerating
// period register and registered quadrature phase / step pulse.
module steer_quad_chan
  import steer_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int ACCEL_SHIFT = 3
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [DIV_W-1:0] eff_div,
  input  logic [DIV_W-1:0] eff_min,
  input  logic             accel_en,
  input  logic             left,
  input  logic             right,
  output logic [1:0]       phase_o,
  output logic             step_o
);

  dir_e             req, dir_q, dir_d;
  logic [1:0]       phase_q, phase_d;
  logic             step_q, step_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [DIV_W-1:0] shrunk, next_period;

  always_comb begin
    req = DIR_IDLE;
    if (right && !left)      req = DIR_RIGHT;
    else if (left && !right) req = DIR_LEFT;
  end

  // eff_min >= 1 so the reloaded count never underflows.
  always_comb begin
    shrunk = period_q - (period_q >> ACCEL_SHIFT);
    if (!accel_en)             next_period = eff_div;
    else if (shrunk < eff_min) next_period = eff_min;
    else                       next_period = shrunk;
  end

  always_comb begin
    dir_d    = req;
    phase_d  = phase_q;
    step_d   = 1'b0;
    cnt_d    = eff_div - DIV_W'(1);
    period_d = eff_div;
    if (req != DIR_IDLE && req == dir_q) begin
      period_d = period_q;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DIV_W'(1);
      end else begin
        phase_d  = next_phase(phase_q, req);
        step_d   = 1'b1;
        period_d = next_period;
        cnt_d    = next_period - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      dir_q    <= DIR_IDLE;
      phase_q  <= PH0;
      step_q   <= 1'b0;
      cnt_q    <= eff_div - DIV_W'(1);
      period_q <= eff_div;
    end else begin
      dir_q    <= dir_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign phase_o = phase_q;
  assign step_o  = step_q;

endmodule

// File: rtl/steer_quad_multi.sv
// N_CH-channel left/right to quadrature steering encoder with programmable
// step period and optional acceleration; sanitised periods shared by all lanes.
module steer_quad_multi
  import steer_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_SHIFT = 3
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [DIV_W-1:0]    clkdiv,
  input  logic [DIV_W-1:0]    clkdiv_min,
  input  logic                accel_en,
  input  logic [N_CH-1:0]     left,
  input  logic [N_CH-1:0]     right,
  output logic [2*N_CH-1:0]   steer,
  output logic [N_CH-1:0]     step_o
);

  logic [DIV_W-1:0]         eff_div, min_clamp, eff_min;
  logic [N_CH-1:0][1:0]     phase_w;

  always_comb begin
    eff_div   = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
    min_clamp = (clkdiv_min == '0) ? DIV_W'(1) : clkdiv_min;
    eff_min   = (min_clamp > eff_div) ? eff_div : min_clamp;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    steer_quad_chan #(
      .DIV_W       (DIV_W),
      .ACCEL_SHIFT (ACCEL_SHIFT)
    ) u_chan (
      .CLK      (CLK),
      .Reset_n  (Reset_n),
      .eff_div  (eff_div),
      .eff_min  (eff_min),
      .accel_en (accel_en),
      .left     (left[i]),
      .right    (right[i]),
      .phase_o  (phase_w[i]),
      .step_o   (step_o[i])
    );
  end

  assign steer = phase_w;

endmodule

// File: tb/tb_steer_quad_multi.sv
// Bench for steer_quad_multi: directed and random holds against a model that
// tracks absolute step times and a position count per channel.
module tb_steer_quad_multi;
  localparam int N_CH = 2;
  localparam int DIV_W = 16;
  localparam int SH = 2;

  logic              CLK = 1'b0;
  logic              Reset_n;
  logic [DIV_W-1:0]  clkdiv, clkdiv_min;
  logic              accel_en;
  logic [N_CH-1:0]   left, right;
  logic [2*N_CH-1:0] steer;
  logic [N_CH-1:0]   step_o;

  steer_quad_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .ACCEL_SHIFT(SH)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .clkdiv_min(clkdiv_min),
    .accel_en(accel_en), .left(left), .right(right), .steer(steer), .step_o(step_o)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  int edge_n = 0;
  int pos[N_CH], ldir[N_CH], per[N_CH], nxt[N_CH];
  logic [N_CH-1:0] exp_step;
  int step_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [1:0] ph_of(input int p);
    case (p % 4)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // One clock: drive at negedge, update model at posedge, compare 1ns later.
  task automatic tick(input logic rn, input logic [N_CH-1:0] l, input logic [N_CH-1:0] r);
    int ed, em, rq, np;
    @(negedge CLK);
    Reset_n = rn; left = l; right = r;
    @(posedge CLK);
    edge_n++;
    ed = (clkdiv == 0) ? 1 : int'(clkdiv);
    em = (clkdiv_min == 0) ? 1 : int'(clkdiv_min);
    if (em > ed) em = ed;
    for (int c = 0; c < N_CH; c++) begin
      rq = (r[c] && !l[c]) ? 1 : (l[c] && !r[c]) ? 2 : 0;
      exp_step[c] = 1'b0;
      if (!rn) begin
        pos[c] = 0; ldir[c] = 0; per[c] = ed;
      end else if (rq == 0 || rq != ldir[c]) begin
        ldir[c] = rq; per[c] = ed; nxt[c] = edge_n + ed;
      end else if (edge_n == nxt[c]) begin
        pos[c] = pos[c] + ((rq == 1) ? 1 : 3);
        if (accel_en) begin
          np = per[c] - per[c] / (1 << SH);
          if (np < em) np = em;
        end else np = ed;
        per[c] = np; nxt[c] = edge_n + np;
        exp_step[c] = 1'b1;
      end
    end
    #1;
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("steer%0d", c), 32'(steer[2*c +: 2]), 32'(ph_of(pos[c])));
      chk($sformatf("step%0d", c), 32'(step_o[c]), 32'(exp_step[c]));
    end
    if (step_o[0]) step_log.push_back(edge_n);
  endtask

  task automatic hold(input int n, input logic [N_CH-1:0] l, input logic [N_CH-1:0] r);
    for (int k = 0; k < n; k++) tick(1'b1, l, r);
  endtask

  initial begin
    int p0;
    int ivl[8] = '{64, 48, 36, 27, 21, 16, 16, 16};
    logic [N_CH-1:0] cl, cr;
    for (int c = 0; c < N_CH; c++) begin pos[c] = 0; ldir[c] = 0; per[c] = 1; nxt[c] = 0; end
    Reset_n = 1'b0; left = '0; right = '0;
    clkdiv = 16'd4; clkdiv_min = 16'd1; accel_en = 1'b0;

    // 1: reset with toggling requests, then long idle
    for (int k = 0; k < 10; k++) tick(1'b0, N_CH'(k), N_CH'(k + 1));
    chk("reset_steer", 32'(steer), 32'd0);
    hold(100, '0, '0);

    // 2/3: constant rate each channel, then clkdiv=0
    hold(20, 2'b00, 2'b01);
    hold(3, 2'b00, 2'b00);
    hold(20, 2'b10, 2'b00);
    clkdiv = 16'd0;
    hold(10, 2'b10, 2'b00);
    clkdiv = 16'd4;

    // 4: both pressed, release one, reverse mid-count
    hold(50, 2'b01, 2'b01);
    hold(6, 2'b00, 2'b01);
    hold(10, 2'b01, 2'b00);

    // 5: acceleration profile and re-press
    hold(2, 2'b00, 2'b00);
    clkdiv = 16'd64; clkdiv_min = 16'd16; accel_en = 1'b1;
    step_log.delete();
    tick(1'b1, 2'b00, 2'b01);
    p0 = edge_n;
    hold(244, 2'b00, 2'b01);
    chk("accel_nsteps", 32'(step_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < step_log.size(); k++)
      chk($sformatf("accel_ivl%0d", k), 32'(step_log[k] - ((k == 0) ? p0 : step_log[k-1])), 32'(ivl[k]));
    hold(3, 2'b00, 2'b00);
    step_log.delete();
    tick(1'b1, 2'b00, 2'b01);
    p0 = edge_n;
    hold(100, 2'b00, 2'b01);
    chk("repress_ivl", (step_log.size() > 0) ? 32'(step_log[0] - p0) : 32'hFFFF, 32'd64);

    // 6: reset mid accelerated hold, then base period again
    tick(1'b0, 2'b00, 2'b01);
    chk("midrst_steer", 32'(steer), 32'd0);
    chk("midrst_step", 32'(step_o), 32'd0);
    step_log.delete();
    tick(1'b1, 2'b00, 2'b01);
    p0 = edge_n;
    hold(80, 2'b00, 2'b01);
    chk("postrst_ivl", (step_log.size() > 0) ? 32'(step_log[0] - p0) : 32'hFFFF, 32'd64);

    // random segments: small periods, mixed accel, occasional reset
    cl = '0; cr = '0;
    for (int s = 0; s < 150; s++) begin
      clkdiv = 16'($urandom_range(0, 6));
      clkdiv_min = 16'($urandom_range(0, 6));
      accel_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        cl = N_CH'($urandom);
        cr = N_CH'($urandom);
      end
      if ($urandom_range(0, 19) == 0) tick(1'b0, cl, cr);
      hold($urandom_range(1, 30), cl, cr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
